// File: rtl/carrier_event_gen_pkg.sv
// Shared types and width defaults for the PWM carrier / event generator slice.
`ifndef CARR_WIDTH
`define CARR_WIDTH 16
`endif
`ifndef EVTCOUNT_WIDTH
`define EVTCOUNT_WIDTH 8
`endif

package carrier_event_gen_pkg;

   typedef enum logic [1:0] {
      CARR_UP     = 2'd0,
      CARR_DOWN   = 2'd1,
      CARR_UPDOWN = 2'd2
   } _carr_mode;

   typedef enum logic {
      CARR_OFF = 1'b0,
      CARR_ON  = 1'b1
   } _carr_onoff;

   typedef enum logic [1:0] {
      NO_MASK = 2'd0,
      MIN     = 2'd1,
      MAX     = 2'd2,
      MINMAX  = 2'd3
   } _mask_mode;

   typedef enum logic {
      UP   = 1'b0,
      DOWN = 1'b1
   } _dir_state;

   function automatic logic mask_sel(input _mask_mode m, input logic mn, input logic mx);
      case (m)
         MIN:     return mn;
         MAX:     return mx;
         MINMAX:  return mn | mx;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/carrier_event_gen_shadow.sv
// Period / mode shadow registers; load at period boundaries, while off, or in reset.
module carr_shadow_reg
   import carrier_event_gen_pkg::*;
#(
   parameter int unsigned CARR_WIDTH = `CARR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  _carr_onoff            carr_onoff,
   input  _carr_mode             carr_mode,
   input  logic [CARR_WIDTH-1:0] period,
   input  logic [CARR_WIDTH-1:0] carrier,
   output logic                  load,
   output _carr_mode             mode_sh,
   output logic [CARR_WIDTH-1:0] per_nxt,
   output _carr_mode             mode_nxt
);

   logic [CARR_WIDTH-1:0] per_sh;

   // Boundary is the cycle the carrier leaves its turning point for the active mode.
   always_comb begin
      load = 1'b0;
      if (carr_onoff == CARR_OFF)
         load = 1'b1;
      else if (mode_sh == CARR_UP)
         load = (carrier == per_sh);
      else
         load = (carrier == '0);
   end

   assign per_nxt  = load ? period    : per_sh;
   assign mode_nxt = load ? carr_mode : mode_sh;

   always_ff @(posedge clk) begin
      if (!reset) begin
         per_sh  <= period;
         mode_sh <= carr_mode;
      end else if (load) begin
         per_sh  <= period;
         mode_sh <= carr_mode;
      end
   end

endmodule

// File: rtl/carrier_event_gen.sv
// Carrier counter (up / down / triangle) with min/max events and mask-selected event pulse.
module carrier_event_gen
   import carrier_event_gen_pkg::*;
#(
   parameter int unsigned CARR_WIDTH = `CARR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  _carr_onoff            carr_onoff,
   input  _carr_mode             carr_mode,
   input  _mask_mode             maskmode,
   input  logic [CARR_WIDTH-1:0] period,
   output logic [CARR_WIDTH-1:0] carrier_out,
   output logic                  dir_out,
   output logic                  evt_min,
   output logic                  evt_max,
   output logic                  maskevent_out
);

   localparam logic [CARR_WIDTH-1:0] CARR_ONE = CARR_WIDTH'(1);

   _dir_state             state, state_nxt;
   logic [CARR_WIDTH-1:0] carr_nxt;
   logic [CARR_WIDTH-1:0] per_nxt;
   _carr_mode             mode_sh, mode_nxt;
   logic                  load;
   logic                  run;
   logic                  min_nxt, max_nxt;

   carr_shadow_reg #(.CARR_WIDTH(CARR_WIDTH)) u_shadow (
      .clk        (clk),
      .reset      (reset),
      .carr_onoff (carr_onoff),
      .carr_mode  (carr_mode),
      .period     (period),
      .carrier    (carrier_out),
      .load       (load),
      .mode_sh    (mode_sh),
      .per_nxt    (per_nxt),
      .mode_nxt   (mode_nxt)
   );

   assign run = (carr_onoff == CARR_ON);

   // Next carrier uses the freshly loaded shadow values so a boundary reload applies immediately.
   always_comb begin
      carr_nxt  = carrier_out;
      state_nxt = state;
      if (!run || per_nxt == '0 || (load && mode_nxt != mode_sh)) begin
         carr_nxt  = (mode_nxt == CARR_DOWN && run && per_nxt != '0) ? per_nxt :
                     (mode_nxt == CARR_DOWN && !run)                  ? per_nxt : '0;
         state_nxt = (mode_nxt == CARR_DOWN) ? DOWN : UP;
      end else begin
         case (mode_nxt)
            CARR_UP: begin
               carr_nxt  = (carrier_out >= per_nxt) ? '0 : carrier_out + CARR_ONE;
               state_nxt = UP;
            end
            CARR_DOWN: begin
               carr_nxt  = (carrier_out == '0) ? per_nxt : carrier_out - CARR_ONE;
               state_nxt = DOWN;
            end
            CARR_UPDOWN: begin
               if (state == UP) begin
                  if (carrier_out >= per_nxt) begin
                     carr_nxt  = carrier_out - CARR_ONE;
                     state_nxt = DOWN;
                  end else begin
                     carr_nxt  = carrier_out + CARR_ONE;
                  end
               end else begin
                  if (carrier_out == '0) begin
                     carr_nxt  = CARR_ONE;
                     state_nxt = UP;
                  end else begin
                     carr_nxt  = carrier_out - CARR_ONE;
                  end
               end
            end
            default: begin
               carr_nxt  = '0;
               state_nxt = UP;
            end
         endcase
      end
   end

   assign min_nxt = run && (carr_nxt == '0);
   assign max_nxt = run && (carr_nxt == per_nxt);

   always_ff @(posedge clk) begin
      if (!reset) begin
         carrier_out   <= '0;
         state         <= UP;
         evt_min       <= 1'b0;
         evt_max       <= 1'b0;
         maskevent_out <= 1'b0;
      end else begin
         carrier_out   <= carr_nxt;
         state         <= state_nxt;
         evt_min       <= min_nxt;
         evt_max       <= max_nxt;
         maskevent_out <= mask_sel(maskmode, min_nxt, max_nxt);
      end
   end

   assign dir_out = (state == DOWN);

endmodule

// File: tb/tb_carrier_event_gen.sv
// Directed scoreboard bench for carrier_event_gen.
module tb_carrier_event_gen;
   import carrier_event_gen_pkg::*;

   localparam int unsigned W = 16;

   logic         clk = 1'b0;
   logic         reset;
   _carr_onoff   carr_onoff;
   _carr_mode    carr_mode;
   _mask_mode    maskmode;
   logic [W-1:0] period;
   logic [W-1:0] carrier_out;
   logic         dir_out, evt_min, evt_max, maskevent_out;

   typedef struct packed {
      logic [W-1:0] c;
      logic         d;
      logic         mn;
      logic         mx;
      logic         mev;
   } obs_t;

   obs_t  sb[$];
   int    errors = 0;
   int    checks = 0;
   string tag = "init";

   always #5 clk = ~clk;

   carrier_event_gen #(.CARR_WIDTH(W)) dut (
      .clk           (clk),
      .reset         (reset),
      .carr_onoff    (carr_onoff),
      .carr_mode     (carr_mode),
      .maskmode      (maskmode),
      .period        (period),
      .carrier_out   (carrier_out),
      .dir_out       (dir_out),
      .evt_min       (evt_min),
      .evt_max       (evt_max),
      .maskevent_out (maskevent_out)
   );

   task automatic expect_cyc(input int c, input bit d, input bit mn, input bit mx, input bit mev);
      obs_t e;
      e.c = W'(c); e.d = d; e.mn = mn; e.mx = mx; e.mev = mev;
      sb.push_back(e);
   endtask

   task automatic run(input int n);
      obs_t o, e;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         o.c = carrier_out; o.d = dir_out; o.mn = evt_min; o.mx = evt_max; o.mev = maskevent_out;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s: scoreboard empty at cycle %0d", tag, i);
         end else begin
            e = sb.pop_front();
            assert (o === e) else begin
               errors++;
               $error("FAIL %s cyc%0d: got c=%0d d=%b min=%b max=%b mev=%b, want c=%0d d=%b min=%b max=%b mev=%b",
                      tag, i, o.c, o.d, o.mn, o.mx, o.mev, e.c, e.d, e.mn, e.mx, e.mev);
            end
         end
      end
   endtask

   task automatic do_reset(input _carr_mode m, input int p, input _mask_mode mk);
      reset      = 1'b0;
      carr_onoff = CARR_ON;
      carr_mode  = m;
      period     = W'(p);
      maskmode   = mk;
      expect_cyc(0, 0, 0, 0, 0);
      run(1);
      reset = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ud_c[6];
      bit ud_d[6];
      ud_c = '{1, 2, 3, 2, 1, 0};
      ud_d = '{0, 0, 0, 1, 1, 1};

      reset = 1'b0; carr_onoff = CARR_ON; carr_mode = CARR_UP; maskmode = MAX; period = '0;

      tag = "up_p4_max";
      do_reset(CARR_UP, 4, MAX);
      for (int k = 1; k <= 10; k++) expect_cyc(k % 5, 0, (k % 5) == 0, (k % 5) == 4, (k % 5) == 4);
      run(10);

      tag = "updown_p3_minmax";
      do_reset(CARR_UPDOWN, 3, MINMAX);
      for (int r = 0; r < 2; r++)
         for (int k = 0; k < 6; k++)
            expect_cyc(ud_c[k], ud_d[k], ud_c[k] == 0, ud_c[k] == 3, ud_c[k] == 0 || ud_c[k] == 3);
      run(12);

      tag = "up_period_change";
      do_reset(CARR_UP, 8, MAX);
      for (int c = 1; c <= 3; c++) expect_cyc(c, 0, 0, 0, 0);
      run(3);
      period = W'(5);
      for (int c = 4; c <= 8; c++) expect_cyc(c, 0, 0, c == 8, c == 8);
      for (int c = 0; c <= 5; c++) expect_cyc(c, 0, c == 0, c == 5, c == 5);
      expect_cyc(0, 0, 1, 0, 0);
      run(12);

      tag = "down_off_on";
      do_reset(CARR_DOWN, 6, MIN);
      for (int c = 6; c >= 2; c--) expect_cyc(c, 1, 0, c == 6, 0);
      run(5);
      carr_onoff = CARR_OFF;
      for (int k = 0; k < 3; k++) expect_cyc(6, 1, 0, 0, 0);
      run(3);
      carr_onoff = CARR_ON;
      for (int c = 5; c >= 0; c--) expect_cyc(c, 1, c == 0, 0, c == 0);
      expect_cyc(6, 1, 0, 1, 0);
      run(7);

      tag = "updown_midreset";
      do_reset(CARR_UPDOWN, 10, MINMAX);
      for (int c = 1; c <= 7; c++) expect_cyc(c, 0, 0, 0, 0);
      run(7);
      reset = 1'b0;
      expect_cyc(0, 0, 0, 0, 0);
      run(1);
      reset = 1'b1;
      for (int c = 1; c <= 3; c++) expect_cyc(c, 0, 0, 0, 0);
      run(3);

      tag = "p0_up_minmax";
      do_reset(CARR_UP, 0, MINMAX);
      for (int k = 0; k < 4; k++) expect_cyc(0, 0, 1, 1, 1);
      run(4);
      tag = "p0_nomask";
      maskmode = NO_MASK;
      for (int k = 0; k < 2; k++) expect_cyc(0, 0, 1, 1, 0);
      run(2);
      tag = "p0_down";
      maskmode  = MINMAX;
      carr_mode = CARR_DOWN;
      for (int k = 0; k < 3; k++) expect_cyc(0, 1, 1, 1, 1);
      run(3);
      tag = "p0_updown";
      carr_mode = CARR_UPDOWN;
      for (int k = 0; k < 2; k++) expect_cyc(0, 0, 1, 1, 1);
      run(2);

      tag = "scoreboard_drained";
      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL %s: got %0d leftover entries, want 0", tag, sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
